// File: rtl/transmitter_frame_scheduler.sv
// Frame scheduler feeding an 8b10b encoder: alignment commas, control frames and data frames.
// Optional CRC-8 byte before EOP is compiled in with `define TX_FRAME_CRC8_EN.
module transmitter_frame_scheduler #(
   parameter int IDLE_INTERVAL  = 64,
   parameter int MAX_PACKET_LEN = 256
) (
   input  logic       i_clk_120,
   input  logic       i_clk_120_rst,
   input  logic       i_data_valid,
   input  logic [7:0] i_data_byte,
   input  logic       i_data_last,
   output logic       o_data_ready,
   input  logic       i_ctrl_req,
   input  logic       i_ctrl_type,
   input  logic [7:0] i_ctrl_id,
   output logic       o_ctrl_ack,
   output logic       o_packet_k_en,
   output logic [7:0] o_packet_byte,
   output logic       o_len_err,
   output logic       o_busy
);

   localparam int CW = $clog2(IDLE_INTERVAL + 1);
   localparam int PW = $clog2(MAX_PACKET_LEN + 1);

   localparam logic [7:0] K_COMMA = 8'hBC;
   localparam logic [7:0] K_SOP   = 8'hFB;
   localparam logic [7:0] K_EOP   = 8'hFD;
   localparam logic [7:0] K_SOC   = 8'h3C;

   typedef enum logic [3:0] {
      IDLE,
      COMMA,
      CTRL_SOC,
      CTRL_TYPE,
      CTRL_ID,
      DATA_SOP,
      DATA,
      DATA_CRC,
      DATA_EOP,
      DROP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   state_t          close_state;
   logic [CW-1:0]   comma_cnt;
   logic [PW-1:0]   pay_cnt;
   logic            comma_due;
   logic            pay_full;
   logic            accept;
   logic            drop_pend;
   logic            overflow;
   logic            ctrl_type_q;
   logic [7:0]      ctrl_id_q;
   logic            sym_k;
   logic [7:0]      sym_byte;

`ifdef TX_FRAME_CRC8_EN
   logic [7:0]      crc;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   assign close_state = DATA_CRC;
`else
   assign close_state = DATA_EOP;
`endif

   assign comma_due = (comma_cnt >= CW'(IDLE_INTERVAL - 1));
   assign pay_full  = (pay_cnt == PW'(MAX_PACKET_LEN - 1));
   assign accept    = o_data_ready & i_data_valid;
   assign overflow  = (state == DATA) & i_data_valid & ~i_data_last & pay_full;

   always_ff @(posedge i_clk_120) begin
      if (i_clk_120_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (comma_due)         state_nxt = COMMA;
            else if (i_ctrl_req)   state_nxt = CTRL_SOC;
            else if (i_data_valid) state_nxt = DATA_SOP;
            else                   state_nxt = IDLE;
         end
         COMMA:     state_nxt = IDLE;
         CTRL_SOC:  state_nxt = CTRL_TYPE;
         CTRL_TYPE: state_nxt = CTRL_ID;
         CTRL_ID:   state_nxt = IDLE;
         DATA_SOP:  state_nxt = DATA;
         DATA: begin
            if (i_data_valid && (i_data_last || pay_full)) state_nxt = close_state;
         end
         DATA_CRC:  state_nxt = DATA_EOP;
         DATA_EOP:  state_nxt = drop_pend ? DROP : IDLE;
         DROP: begin
            if (i_data_valid && i_data_last) state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // sym_k/sym_byte is the symbol chosen this cycle; it reaches the encoder on the next edge
   always_comb begin
      sym_k        = 1'b1;
      sym_byte     = K_COMMA;
      o_data_ready = (state == DATA) || (state == DROP);
      o_busy       = !((state == IDLE) || (state == COMMA));
      o_ctrl_ack   = (state == IDLE) & ~comma_due & i_ctrl_req & ~i_clk_120_rst;
      case (state)
         CTRL_SOC: begin
            sym_k    = 1'b1;
            sym_byte = K_SOC;
         end
         CTRL_TYPE: begin
            sym_k    = 1'b0;
            sym_byte = ctrl_type_q ? 8'h02 : 8'h01;
         end
         CTRL_ID: begin
            sym_k    = 1'b0;
            sym_byte = ctrl_id_q;
         end
         DATA_SOP: begin
            sym_k    = 1'b1;
            sym_byte = K_SOP;
         end
         DATA: begin
            if (i_data_valid) begin
               sym_k    = 1'b0;
               sym_byte = i_data_byte;
            end
         end
`ifdef TX_FRAME_CRC8_EN
         DATA_CRC: begin
            sym_k    = 1'b0;
            sym_byte = crc;
         end
`endif
         DATA_EOP: begin
            sym_k    = 1'b1;
            sym_byte = K_EOP;
         end
         default: begin
            sym_k    = 1'b1;
            sym_byte = K_COMMA;
         end
      endcase
   end

   always_ff @(posedge i_clk_120) begin
      if (i_clk_120_rst) begin
         o_packet_k_en <= 1'b1;
         o_packet_byte <= K_COMMA;
         o_len_err     <= 1'b0;
         comma_cnt     <= '0;
         pay_cnt       <= '0;
         drop_pend     <= 1'b0;
         ctrl_type_q   <= 1'b0;
         ctrl_id_q     <= '0;
      end else begin
         o_packet_k_en <= sym_k;
         o_packet_byte <= sym_byte;
         o_len_err     <= overflow;
         // alignment distance counts every symbol and saturates until the COMMA state resets it
         if (state == COMMA) begin
            comma_cnt <= '0;
         end else if (!comma_due) begin
            comma_cnt <= comma_cnt + CW'(1);
         end
         if (state == DATA_SOP) begin
            pay_cnt <= '0;
         end else if ((state == DATA) && accept) begin
            pay_cnt <= pay_cnt + PW'(1);
         end
         if (overflow) begin
            drop_pend <= 1'b1;
         end else if (state == DATA_EOP) begin
            drop_pend <= 1'b0;
         end
         if (o_ctrl_ack) begin
            ctrl_type_q <= i_ctrl_type;
            ctrl_id_q   <= i_ctrl_id;
         end
      end
   end

`ifdef TX_FRAME_CRC8_EN
   always_ff @(posedge i_clk_120) begin
      if (i_clk_120_rst) begin
         crc <= '0;
      end else if (state == DATA_SOP) begin
         crc <= '0;
      end else if ((state == DATA) && accept) begin
         crc <= crc8_step(crc, i_data_byte);
      end
   end
`endif

endmodule

// File: tb/tb_transmitter_frame_scheduler.sv
// Bench for transmitter_frame_scheduler: directed scenarios plus random traffic checked
// against a transaction-level model of the expected symbol stream (fillers stripped).
module tb_transmitter_frame_scheduler;

   localparam int II  = 16;
   localparam int MPL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_valid = 1'b0;
   logic [7:0] data_byte = '0;
   logic       data_last = 1'b0;
   logic       data_ready;
   logic       ctrl_req = 1'b0;
   logic       ctrl_type = 1'b0;
   logic [7:0] ctrl_id = '0;
   logic       ctrl_ack;
   logic       k_en;
   logic [7:0] sym;
   logic       len_err;
   logic       busy;

   transmitter_frame_scheduler #(.IDLE_INTERVAL(II), .MAX_PACKET_LEN(MPL)) dut (
      .i_clk_120     (clk),
      .i_clk_120_rst (rst),
      .i_data_valid  (data_valid),
      .i_data_byte   (data_byte),
      .i_data_last   (data_last),
      .o_data_ready  (data_ready),
      .i_ctrl_req    (ctrl_req),
      .i_ctrl_type   (ctrl_type),
      .i_ctrl_id     (ctrl_id),
      .o_ctrl_ack    (ctrl_ack),
      .o_packet_k_en (k_en),
      .o_packet_byte (sym),
      .o_len_err     (len_err),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q[$];
   logic [7:0] pkt[0:7];
   int         exp_acks = 0;
   int         exp_lenerr = 0;
   int         ack_cycles = 0;
   int         lenerr_cycles = 0;
   int         filler_cnt = 0;
   bit         mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1
   function automatic logic [7:0] crc_model(input int n);
      logic [8:0] rem;
      rem = '0;
      for (int i = 0; i < n + 1; i++) begin
         for (int b = 7; b >= 0; b--) begin
            rem = {rem[7:0], (i < n) ? pkt[i][b] : 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
         end
      end
      return rem[7:0];
   endfunction

   task automatic push_ctrl(input logic t, input logic [7:0] id);
      exp_q.push_back({1'b1, 8'h3C});
      exp_q.push_back({1'b0, 8'(t) + 8'd1});
      exp_q.push_back({1'b0, id});
      exp_acks++;
   endtask

   task automatic push_pkt(input int n);
      int kept;
      kept = (n < MPL) ? n : MPL;
      exp_q.push_back({1'b1, 8'hFB});
      for (int i = 0; i < kept; i++) exp_q.push_back({1'b0, pkt[i]});
`ifdef TX_FRAME_CRC8_EN
      exp_q.push_back({1'b0, crc_model(kept)});
`endif
      exp_q.push_back({1'b1, 8'hFD});
      if (n > MPL) exp_lenerr++;
   endtask

   task automatic do_ctrl(input logic t, input logic [7:0] id);
      int cnt;
      ctrl_req = 1'b1; ctrl_type = t; ctrl_id = id;
      cnt = 0;
      @(negedge clk);
      while (!ctrl_ack && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      chk("ack_timeout", 32'(cnt < 300), 32'd1);
      step();
      ctrl_req = 1'b0;
   endtask

   // mode 0: back-to-back, 1: random gaps, 2: fixed 2-cycle gap before byte 1
   task automatic send_pkt(input int n, input int mode);
      int cnt, g;
      for (int i = 0; i < n; i++) begin
         g = 0;
         if (mode == 1 && i > 0 && ($urandom % 3) == 0) g = $urandom_range(1, 3);
         if (mode == 2 && i == 1) g = 2;
         if (g > 0) begin
            data_valid = 1'b0;
            repeat (g) step();
         end
         data_valid = 1'b1; data_byte = pkt[i]; data_last = (i == n - 1);
         cnt = 0;
         @(negedge clk);
         while (!data_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
         end
         chk("ready_timeout", 32'(cnt < 300), 32'd1);
         step();
      end
      data_valid = 1'b0; data_last = 1'b0;
   endtask

   // stream monitor: symbol order, accept-to-output latency, fillers, pulse counts
   initial begin : monitor
      bit         pend;
      logic [7:0] pend_byte;
      int         pend_idx, acc_idx;
      bit         in_frame;
      logic [8:0] e;
      pend = 0; acc_idx = 0; in_frame = 0; pend_byte = '0; pend_idx = 0;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            pend = 0; acc_idx = 0; in_frame = 0;
         end else begin
            if (ctrl_ack) ack_cycles++;
            if (len_err) lenerr_cycles++;
            if (pend) begin
               chk("latency", {23'd0, k_en, sym},
                   (pend_idx < MPL) ? {23'd0, 1'b0, pend_byte} : {23'd0, 1'b1, 8'hBC});
            end
            if (k_en === 1'b1 && sym === 8'hBC) begin
               if (in_frame) filler_cnt++;
            end else if (exp_q.size() == 0) begin
               chk("unexpected_sym", {23'd0, k_en, sym}, 32'h1BC);
            end else begin
               e = exp_q.pop_front();
               chk("sym", {23'd0, k_en, sym}, {23'd0, e});
               if (e == 9'h1FB) in_frame = 1;
               if (e == 9'h1FD) in_frame = 0;
            end
            pend = data_valid && data_ready;
            if (pend) begin
               pend_byte = data_byte;
               pend_idx  = acc_idx;
               acc_idx   = data_last ? 0 : acc_idx + 1;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int kind, n;
      logic t;
      logic [7:0] id;

      // reset values
      repeat (3) step();
      @(negedge clk);
      chk("rst_k", 32'(k_en), 32'd1);
      chk("rst_byte", 32'(sym), 32'hBC);
      chk("rst_ready", 32'(data_ready), 32'd0);
      chk("rst_ack", 32'(ctrl_ack), 32'd0);
      chk("rst_lenerr", 32'(len_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      mon_en = 1'b1;

      // idle: commas only, not busy
      repeat (10) begin
         @(negedge clk);
         chk("idle_sym", {23'd0, k_en, sym}, 32'h1BC);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      step();

      // ACK id 0x5A with exact timing
      push_ctrl(1'b0, 8'h5A);
      do_ctrl(1'b0, 8'h5A);
      @(negedge clk);
      chk("ctrl_busy", 32'(busy), 32'd1);
      chk("ctrl_pre", {23'd0, k_en, sym}, 32'h1BC);
      @(negedge clk); chk("ctrl_soc", {23'd0, k_en, sym}, 32'h13C);
      @(negedge clk); chk("ctrl_type", {23'd0, k_en, sym}, 32'h001);
      @(negedge clk); chk("ctrl_id", {23'd0, k_en, sym}, 32'h05A);
      chk("ack_once", 32'(ack_cycles), 32'd1);
      step();

      // data packet 11 22 33, EOP two cycles after last acceptance
      pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
      push_pkt(3);
      send_pkt(3, 0);
      @(negedge clk);
      chk("last_byte", {23'd0, k_en, sym}, 32'h033);
      @(negedge clk);
`ifdef TX_FRAME_CRC8_EN
      chk("crc_byte", {23'd0, k_en, sym}, {23'd0, 1'b0, crc_model(3)});
      @(negedge clk);
`endif
      chk("eop", {23'd0, k_en, sym}, 32'h1FD);
      step();

      // underrun: two fillers between payload bytes
      repeat (4) step();
      filler_cnt = 0;
      pkt[0] = 8'hA1; pkt[1] = 8'hB2; pkt[2] = 8'hC3;
      push_pkt(3);
      send_pkt(3, 2);
      repeat (6) step();
      chk("fillers", 32'(filler_cnt), 32'd2);

      // simultaneous control and data: control first
      pkt[0] = 8'h01; pkt[1] = 8'h02;
      push_ctrl(1'b1, 8'hC7);
      push_pkt(2);
      fork
         send_pkt(2, 0);
         do_ctrl(1'b1, 8'hC7);
      join
      repeat (8) step();

      // control raised mid-packet: after EOP
      pkt[0] = 8'h44; pkt[1] = 8'h55; pkt[2] = 8'h66; pkt[3] = 8'h77;
      push_pkt(4);
      push_ctrl(1'b0, 8'h3E);
      fork
         send_pkt(4, 0);
         begin
            repeat (3) step();
            do_ctrl(1'b0, 8'h3E);
         end
      join
      repeat (10) step();

      // overflow: 6 bytes with limit 4
      for (int i = 0; i < 6; i++) pkt[i] = 8'(8'h90 + i);
      push_pkt(6);
      send_pkt(6, 0);
      repeat (4) step();
      @(negedge clk);
      chk("ovf_lenerr", 32'(lenerr_cycles), 32'd1);
      chk("ovf_idle", 32'(busy), 32'd0);
      step();

      // random traffic
      for (int r = 0; r < 30; r++) begin
         kind = $urandom % 3;
         if (kind == 0) begin
            t  = 1'($urandom);
            id = 8'($urandom);
            push_ctrl(t, id);
            do_ctrl(t, id);
         end else begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
            push_pkt(n);
            send_pkt(n, 1);
         end
         repeat ($urandom_range(0, 20)) step();
      end
      repeat (30) step();
      @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
      chk("ack_count", 32'(ack_cycles), 32'(exp_acks));
      chk("lenerr_count", 32'(lenerr_cycles), 32'(exp_lenerr));
      step();

      // reset mid-frame: frame abandoned, commas afterwards
      mon_en = 1'b0;
      data_valid = 1'b1; data_byte = 8'hAA; data_last = 1'b0;
      repeat (5) step();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      data_valid = 1'b0;
      @(negedge clk);
      chk("mrst_sym", {23'd0, k_en, sym}, 32'h1BC);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_ready", 32'(data_ready), 32'd0);
      step();
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("post_rst_sym", {23'd0, k_en, sym}, 32'h1BC);
      step();
      pkt[0] = 8'h5C; pkt[1] = 8'hBC;
      push_pkt(2);
      send_pkt(2, 0);
      repeat (8) step();
      @(negedge clk);
      chk("final_drain", 32'(exp_q.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
